// File: rtl/sfx_sequencer.sv
// ============================================================================
// Module   : sfx_sequencer
// Purpose  : Turns game-judgement events (perfect/good/miss/combo) into a
//            timed sequence of notes for the downstream square-wave tone
//            generator. Holds a fixed 4-effect note ROM, a 1 ms tick
//            prescaler, a per-note duration counter and a one-deep
//            pending-trigger slot (last trigger wins).
// Ports    :
//   clk              in   system clock
//   rst              in   asynchronous reset, active low (0 = reset)
//   trig_valid       in   one-cycle pulse: play effect trig_id
//   trig_id[1:0]     in   0=PERFECT 1=GOOD 2=MISS 3=COMBO
//   mute             in   gates tone_en only; timing unaffected
//   tone_half_period out  half-period of current note in clk cycles
//   tone_en          out  high while a note sounds and mute=0
//   busy             out  high in any state but IDLE
//   effect_id        out  effect currently playing
//   note_idx         out  index of current note within the effect
//   done             out  one-cycle pulse when an effect's last note ends
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module sfx_sequencer #(
  parameter int TICK_CYC    = 50000,
  parameter int NOTE_GAP_MS = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trig_valid,
  input  logic [1:0]  trig_id,
  input  logic        mute,
  output logic [16:0] tone_half_period,
  output logic        tone_en,
  output logic        busy,
  output logic [1:0]  effect_id,
  output logic [1:0]  note_idx,
  output logic        done
);

  localparam int             PW         = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_CYC - 1);
  localparam logic [15:0]    GAP_MS     = 16'(NOTE_GAP_MS);
  localparam bit             GAP_ZERO   = (NOTE_GAP_MS == 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_PLAY = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   dur_q, dur_d;
  logic [16:0]   half_period_q, half_period_d;
  logic [1:0]    effect_id_q, effect_id_d;
  logic [1:0]    note_idx_q, note_idx_d;
  logic          done_q, done_d;
  logic          pend_valid_q, pend_valid_d;
  logic [1:0]    pend_id_q, pend_id_d;

  logic [16:0]   rom_half_period;
  logic [7:0]    rom_ms;
  logic [1:0]    last_idx;
  logic          tick;
  logic          count_end;

  // Note ROM: {effect, note} -> (half-period in clk cycles, duration in ms)
  always_comb begin
    rom_half_period = 17'd0;
    rom_ms          = 8'd0;
    case ({effect_id_q, note_idx_q})
      4'b00_00: begin rom_half_period = 17'd47778;  rom_ms = 8'd60;  end
      4'b00_01: begin rom_half_period = 17'd37922;  rom_ms = 8'd60;  end
      4'b00_10: begin rom_half_period = 17'd31888;  rom_ms = 8'd120; end
      4'b01_00: begin rom_half_period = 17'd37922;  rom_ms = 8'd80;  end
      4'b01_01: begin rom_half_period = 17'd31888;  rom_ms = 8'd80;  end
      4'b10_00: begin rom_half_period = 17'd113636; rom_ms = 8'd200; end
      4'b11_00: begin rom_half_period = 17'd47778;  rom_ms = 8'd40;  end
      4'b11_01: begin rom_half_period = 17'd37922;  rom_ms = 8'd40;  end
      4'b11_10: begin rom_half_period = 17'd31888;  rom_ms = 8'd40;  end
      4'b11_11: begin rom_half_period = 17'd23889;  rom_ms = 8'd160; end
      default:  begin rom_half_period = 17'd0;      rom_ms = 8'd0;   end
    endcase
  end

  always_comb begin
    last_idx = 2'd0;
    case (effect_id_q)
      2'd0:    last_idx = 2'd2;
      2'd1:    last_idx = 2'd1;
      2'd2:    last_idx = 2'd0;
      default: last_idx = 2'd3;
    endcase
  end

  // One ms has elapsed on this cycle; the duration counter expires on the
  // tick that consumes its final ms (counter holds remaining ms incl. current).
  assign tick      = (presc_q == PRESC_LAST);
  assign count_end = tick && (dur_q <= 16'd1);

  always_comb begin
    state_d       = state_q;
    presc_d       = presc_q;
    dur_d         = dur_q;
    half_period_d = half_period_q;
    effect_id_d   = effect_id_q;
    note_idx_d    = note_idx_q;
    done_d        = 1'b0;
    pend_valid_d  = pend_valid_q;
    pend_id_d     = pend_id_q;

    // Any trigger while busy lands in the pending slot; newest overwrites.
    if (trig_valid && (state_q != S_IDLE)) begin
      pend_valid_d = 1'b1;
      pend_id_d    = trig_id;
    end

    case (state_q)
      S_IDLE: begin
        if (trig_valid) begin
          effect_id_d = trig_id;
          note_idx_d  = 2'd0;
          state_d     = S_LOAD;
        end
      end

      S_LOAD: begin
        half_period_d = rom_half_period;
        dur_d         = {8'd0, rom_ms};
        presc_d       = '0;
        state_d       = S_PLAY;
      end

      S_PLAY: begin
        presc_d = tick ? '0 : presc_q + PW'(1);
        if (tick && !count_end) begin
          dur_d = dur_q - 16'd1;
        end
        if (count_end) begin
          if (note_idx_q != last_idx) begin
            note_idx_d = note_idx_q + 2'd1;
          end else begin
            done_d = 1'b1;
            // A trigger arriving on this very cycle counts as pending.
            if (trig_valid || pend_valid_q) begin
              effect_id_d  = trig_valid ? trig_id : pend_id_q;
              note_idx_d   = 2'd0;
              pend_valid_d = 1'b0;
            end
          end
          if ((note_idx_q == last_idx) && !trig_valid && !pend_valid_q) begin
            state_d = S_IDLE;
          end else if (GAP_ZERO) begin
            state_d = S_LOAD;
          end else begin
            state_d = S_GAP;
            dur_d   = GAP_MS;
            presc_d = '0;
          end
        end
      end

      S_GAP: begin
        presc_d = tick ? '0 : presc_q + PW'(1);
        if (tick && !count_end) begin
          dur_d = dur_q - 16'd1;
        end
        if (count_end) begin
          state_d = S_LOAD;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      presc_q       <= '0;
      dur_q         <= 16'd0;
      half_period_q <= 17'd0;
      effect_id_q   <= 2'd0;
      note_idx_q    <= 2'd0;
      done_q        <= 1'b0;
      pend_valid_q  <= 1'b0;
      pend_id_q     <= 2'd0;
    end else begin
      state_q       <= state_d;
      presc_q       <= presc_d;
      dur_q         <= dur_d;
      half_period_q <= half_period_d;
      effect_id_q   <= effect_id_d;
      note_idx_q    <= note_idx_d;
      done_q        <= done_d;
      pend_valid_q  <= pend_valid_d;
      pend_id_q     <= pend_id_d;
    end
  end

  assign tone_half_period = half_period_q;
  assign tone_en          = (state_q == S_PLAY) && !mute;
  assign busy             = (state_q != S_IDLE);
  assign effect_id        = effect_id_q;
  assign note_idx         = note_idx_q;
  assign done             = done_q;

endmodule

`default_nettype wire

// File: tb/tb_sfx_sequencer.sv
// ============================================================================
// Module   : tb_sfx_sequencer
// Purpose  : Self-checking bench for sfx_sequencer. Note and done
//            expectations are queued when triggers are issued; a monitor
//            pops them on tone_en edges and done pulses. A second instance
//            with NOTE_GAP_MS=0 covers back-to-back notes.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_sfx_sequencer;

  localparam int TICK = 10;
  localparam int GAP  = 5;
  localparam int G    = GAP * TICK + 1;  // silent cycles between notes (GAP + LOAD)

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        trig_valid = 1'b0;
  logic [1:0]  trig_id = 2'd0;
  logic        mute = 1'b0;
  logic [16:0] tone_half_period;
  logic        tone_en, busy, done;
  logic [1:0]  effect_id, note_idx;

  logic        trig_valid0 = 1'b0;
  logic [1:0]  trig_id0 = 2'd0;
  logic        mute0 = 1'b0;
  logic [16:0] hp0;
  logic        tone_en0, busy0, done0;
  logic [1:0]  eff0, idx0;

  sfx_sequencer #(.TICK_CYC(TICK), .NOTE_GAP_MS(GAP)) dut (
    .clk(clk), .rst(rst), .trig_valid(trig_valid), .trig_id(trig_id),
    .mute(mute), .tone_half_period(tone_half_period), .tone_en(tone_en),
    .busy(busy), .effect_id(effect_id), .note_idx(note_idx), .done(done)
  );

  sfx_sequencer #(.TICK_CYC(TICK), .NOTE_GAP_MS(0)) dut0 (
    .clk(clk), .rst(rst), .trig_valid(trig_valid0), .trig_id(trig_id0),
    .mute(mute0), .tone_half_period(hp0), .tone_en(tone_en0),
    .busy(busy0), .effect_id(eff0), .note_idx(idx0), .done(done0)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct { int hp; int eff; int idx; int start; int len; } note_t;
  typedef struct { int at; int busy; } done_t;
  note_t note_q[$];
  done_t done_q[$];
  bit    mon_notes = 1'b1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Hand-entered note table
  function automatic int n_notes(input int e);
    case (e)
      0: return 3;
      1: return 2;
      2: return 1;
      default: return 4;
    endcase
  endfunction

  function automatic int exp_hp(input int e, input int n);
    case (e * 4 + n)
      0: return 47778;   1: return 37922;   2: return 31888;
      4: return 37922;   5: return 31888;
      8: return 113636;
      12: return 47778;  13: return 37922;  14: return 31888;  15: return 23889;
      default: return -1;
    endcase
  endfunction

  function automatic int exp_ms(input int e, input int n);
    case (e * 4 + n)
      0: return 60;   1: return 60;   2: return 120;
      4: return 80;   5: return 80;
      8: return 200;
      12: return 40;  13: return 40;  14: return 40;  15: return 160;
      default: return -1;
    endcase
  endfunction

  // Queue an effect whose first note sounds at 'start'; returns the done cycle.
  task automatic push_effect(input int e, input int start, input int busy_at_done,
                             input bit with_notes, output int done_at);
    int t;
    t = start;
    for (int n = 0; n < n_notes(e); n++) begin
      note_t x;
      x.hp = exp_hp(e, n); x.eff = e; x.idx = n; x.start = t;
      x.len = exp_ms(e, n) * TICK;
      if (with_notes) note_q.push_back(x);
      t += x.len;
      if (n != n_notes(e) - 1) t += G;
    end
    done_at = t;
    done_q.push_back('{at: t, busy: busy_at_done});
  endtask

  // Called on a negedge; trigger is high for cycle 't'.
  task automatic trigger(input int id, output int t);
    trig_id    = id[1:0];
    trig_valid = 1'b1;
    t          = cyc;
    @(negedge clk);
    trig_valid = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic drain(input int d);
    wait_until(d + 3);
    chk("queues_empty", note_q.size() + done_q.size(), 0);
    chk("idle_after_effect", int'(busy), 0);
  endtask

  // Monitor: compares notes on tone_en edges and done pulses against queues
  initial begin
    note_t cur;
    done_t de;
    bit    cur_v;
    logic  tone_prev;
    cur_v = 1'b0;
    tone_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_notes) begin
        if (tone_en && !tone_prev) begin
          if (note_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_note: got hp %0d expected no note (cycle %0d)",
                     tone_half_period, cyc);
            cur_v = 1'b0;
          end else begin
            cur = note_q.pop_front();
            cur_v = 1'b1;
            chk("note_hp", int'(tone_half_period), cur.hp);
            chk("note_effect", int'(effect_id), cur.eff);
            chk("note_idx", int'(note_idx), cur.idx);
            chk("note_start", cyc, cur.start);
          end
        end
        if (!tone_en && tone_prev && cur_v) begin
          chk("note_end", cyc, cur.start + cur.len);
          cur_v = 1'b0;
        end
      end else begin
        cur_v = 1'b0;
      end
      tone_prev = tone_en;
      if (done) begin
        if (done_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
        end else begin
          de = done_q.pop_front();
          chk("done_cycle", cyc, de.at);
          chk("busy_at_done", int'(busy), de.busy);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, tx, d, d1, d2, bad, s;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tone_en", int'(tone_en), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_half_period", int'(tone_half_period), 0);
    chk("rst_effect_id", int'(effect_id), 0);
    chk("rst_note_idx", int'(note_idx), 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // MISS: one 200 ms note, done at trigger+2002
    trigger(2, t0);
    push_effect(2, t0 + 2, 0, 1'b1, d);
    chk("miss_done_at", d - t0, 2002);
    drain(d);

    // PERFECT: three notes, walks note_idx 0,1,2
    trigger(0, t0);
    push_effect(0, t0 + 2, 0, 1'b1, d);
    drain(d);

    // Trigger on the last PLAY cycle of MISS: queued, plays after the gap
    trigger(2, t0);
    push_effect(2, t0 + 2, 1, 1'b1, d1);
    wait_until(t0 + 2001);
    trigger(0, t1);
    push_effect(0, d1 + G, 0, 1'b1, d2);
    drain(d2);

    // Chaining: GOOD, then COMBO and GOOD while busy -> GOOD replays
    trigger(1, t0);
    push_effect(1, t0 + 2, 1, 1'b1, d1);
    wait_until(t0 + 100);
    trigger(3, tx);
    wait_until(t0 + 200);
    trigger(1, tx);
    push_effect(1, d1 + G, 0, 1'b1, d2);
    bad = 0;
    while (cyc < d2) begin
      if (!busy) bad++;
      @(negedge clk);
    end
    chk("chain_busy_drops", bad, 0);
    drain(d2);

    // Mute during the first 300 cycles of MISS
    mon_notes = 1'b0;
    mute = 1'b1;
    trigger(2, t0);
    push_effect(2, t0 + 2, 0, 1'b0, d);
    wait_until(t0 + 100);
    chk("mute_tone_off", int'(tone_en), 0);
    chk("mute_busy", int'(busy), 1);
    wait_until(t0 + 302);
    mute = 1'b0;
    wait_until(t0 + 400);
    chk("unmute_tone_on", int'(tone_en), 1);
    chk("unmute_hp", int'(tone_half_period), 113636);
    drain(d);

    // Async reset mid-PLAY with a pending trigger
    trigger(1, t0);
    wait_until(t0 + 20);
    trigger(3, tx);
    wait_until(t0 + 100);
    chk("pre_reset_tone", int'(tone_en), 1);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("arst_tone_en", int'(tone_en), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_half_period", int'(tone_half_period), 0);
    chk("arst_effect_id", int'(effect_id), 0);
    chk("arst_note_idx", int'(note_idx), 0);
    chk("arst_done", int'(done), 0);
    @(negedge clk);
    rst = 1'b1;
    bad = 0;
    repeat (3000) begin
      @(negedge clk);
      if (busy || tone_en || done) bad++;
    end
    chk("post_reset_activity", bad, 0);
    mon_notes = 1'b1;

    // NOTE_GAP_MS=0 instance: COMBO notes separated by exactly one LOAD cycle
    trig_id0 = 2'd3;
    trig_valid0 = 1'b1;
    t0 = cyc;
    @(negedge clk);
    trig_valid0 = 1'b0;
    s = t0 + 2;
    for (int n = 0; n < 4; n++) begin
      if (n > 0) begin
        wait_until(s - 2);
        chk("gap0_prev_note_on", int'(tone_en0), 1);
      end
      wait_until(s - 1);
      chk("gap0_silent_cycle", int'(tone_en0), 0);
      wait_until(s);
      chk("gap0_note_on", int'(tone_en0), 1);
      chk("gap0_hp", int'(hp0), exp_hp(3, n));
      chk("gap0_idx", int'(idx0), n);
      s += exp_ms(3, n) * TICK;
      if (n != 3) s += 1;
    end
    wait_until(s);
    chk("gap0_done", int'(done0), 1);
    chk("gap0_idle", int'(busy0), 0);

    repeat (5) @(negedge clk);
    chk("final_queues_empty", note_q.size() + done_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
